// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan controller.
//   NUM_DIGITS        number of multiplexed digits
//   DATA_OFS/MASK_OFS bus byte offsets of the pending registers
//   DATA_RST/MASK_RST reset values of the pending and shadow registers
//   GLYPH_*           active-low A..G patterns (bit 6 = A, bit 0 = G)
//   reg_sel_e         decoded register target of a bus offset
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [3:0] DATA_OFS = 4'h0;
  localparam logic [3:0] MASK_OFS = 4'h4;

  localparam logic [31:0] DATA_RST = '0;
  // MASK[7:0] digit enables, MASK[15:8] decimal points; upper half reads 0.
  localparam logic [15:0] MASK_RST = 16'h00FF;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_MASK,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [3:0] addr);
    if (addr == DATA_OFS)      return REG_DATA;
    else if (addr == MASK_OFS) return REG_MASK;
    else                       return REG_NONE;
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational hex nibble to active-low seven-segment glyph.
//   nibble in  [3:0]  hex value 0..F
//   seg    out [6:0]  active-low segments, bit 6 = A ... bit 0 = G
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = '1;
    unique case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped eight-digit seven-segment scan controller.
// Software writes DATA (eight hex nibbles) and MASK (digit enables in [7:0],
// decimal points in [15:8]); a shadow copy taken at frame boundaries drives
// the multiplexed pins so a frame is never torn by a write.
//   SCAN_DIV            clock cycles each digit stays lit (>= 2)
//   fpga_clk/fpga_rst   clock, synchronous active-high reset
//   bus_addr/we/wdata   register write port (0x0 DATA, 0x4 MASK)
//   bus_rdata           combinational readback of the pending registers
//   dig_en              active-low digit selects, bit 0 rightmost
//   DN_A..DN_G, DN_DP   active-low shared segment lines
// Optional feature: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst,
  input  logic [3:0]  bus_addr,
  input  logic        bus_we,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [7:0]  dig_en,
  output logic        DN_A,
  output logic        DN_B,
  output logic        DN_C,
  output logic        DN_D,
  output logic        DN_E,
  output logic        DN_F,
  output logic        DN_G,
  output logic        DN_DP
);

  localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PCW-1:0] pcnt;
  logic [2:0]     idx;
  logic [31:0]    data_q, shadow_data, data_d;
  logic [15:0]    mask_q, shadow_mask, mask_d;
  reg_sel_e       sel;
  logic           last_pcnt, boundary;

  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic [31:0] upper;
  logic        lit;
  logic [7:0]  dig_next;
  logic [6:0]  seg_next;
  logic        dp_next;
  logic [7:0]  dig_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  assign sel       = decode_addr(bus_addr);
  assign last_pcnt = (pcnt == PCW'(SCAN_DIV - 1));
  assign boundary  = last_pcnt && (idx == 3'd7);

  // Next pending values double as the shadow source, so a write landing on
  // the boundary cycle reaches the shadow on that same edge.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (bus_we && sel == REG_DATA) data_d = bus_wdata;
    if (bus_we && sel == REG_MASK) mask_d = bus_wdata[15:0];
  end

  always_comb begin
    bus_rdata = '0;
    unique case (sel)
      REG_DATA: bus_rdata = data_q;
      REG_MASK: bus_rdata = {16'h0000, mask_q};
      REG_NONE: bus_rdata = '0;
      default:  bus_rdata = '0;
    endcase
  end

  assign nibble = shadow_data[{idx, 2'b00} +: 4];

  hex7seg_decode u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    upper = shadow_data >> {idx, 2'b00};
    lit   = shadow_mask[idx];
`ifdef SEG7_LZB_EN
    if (idx != 3'd0 && upper == '0) lit = 1'b0;
`endif
    dig_next = '1;
    seg_next = '1;
    dp_next  = 1'b1;
    if (lit) begin
      dig_next = ~(8'd1 << idx);
      seg_next = glyph;
      dp_next  = ~shadow_mask[{1'b1, idx}];
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      pcnt        <= '0;
      idx         <= '0;
      data_q      <= DATA_RST;
      mask_q      <= MASK_RST;
      shadow_data <= DATA_RST;
      shadow_mask <= MASK_RST;
      dig_q       <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      pcnt   <= last_pcnt ? '0 : pcnt + PCW'(1);
      if (last_pcnt) idx <= idx + 3'd1;
      if (boundary) begin
        shadow_data <= data_d;
        shadow_mask <= mask_d;
      end
      dig_q <= dig_next;
      seg_q <= seg_next;
      dp_q  <= dp_next;
    end
  end

  assign dig_en = dig_q;
  assign {DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G} = seg_q;
  assign DN_DP  = dp_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Memory-mapped eight-digit seven-segment display controller for the miniRV SoC. It sits downstream of the CPU data bus. It holds a 32-bit hex display word and a digit/decimal-point mask written by software, and it time-multiplexes them onto `dig_en` and `DN_A`..`DN_DP` at the board pins. A shadow copy is loaded only at frame boundaries, so a write never produces a partly updated (torn) frame.

## Interface
- `SCAN_DIV`, default 20000: `fpga_clk` cycles each digit stays lit; legal range ≥ 2.
- `fpga_clk` in 1: single system clock.
- `fpga_rst` in 1: synchronous, active-high reset.
- `bus_addr` in 4: byte offset. 0x0 is DATA, 0x4 is MASK, all other offsets are unmapped.
- `bus_we` in 1: write strobe for one cycle.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: combinational readback of the pending register at `bus_addr`; unmapped offsets read 0.
- `dig_en` out 8: digit select, active-low; bit 0 is the rightmost digit.
- `DN_A`..`DN_G`, `DN_DP` out 1 each: segment lines, active-low, shared by all digits.

## Operation
- **Pending registers**
  - DATA[31:0]: digit i displays nibble DATA[4i+3:4i].
  - MASK[7:0]: per-digit enable. MASK[15:8]: per-digit decimal point. MASK[31:16] reads 0.
  - Reset values: DATA = 0, MASK = 0x0000_00FF.
- **Shadow registers**
  - Contents: shadow DATA and shadow MASK, with the same reset values as the pending registers.
  - Load rule: they load from the pending registers only at a frame boundary.
  - Bypass: if a write occurs on the boundary cycle, the shadow loads the newly written value.
- **Scan counters**
  - Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps.
  - Digit index `idx` counts 0..7 and increments when `pcnt` = SCAN_DIV-1.
  - Frame boundary: `pcnt` = SCAN_DIV-1 and `idx` = 7.
- **Output stage**, registered from `idx` and the shadow registers:
  - Active digit `idx` with shadow MASK[idx] = 1: `dig_en` is one-hot-low at `idx`; segments show the hex glyph of the nibble; `DN_DP` = ~MASK[8+idx].
  - Masked digit (MASK[idx] = 0): `dig_en` = 0xFF and all segments = 1 for that slot.
- **Hex glyphs** (standard):
  - 0 → A..G = 0000001.
  - 1 → 1001111.
  - 8 → 0000000.
  - A → 0001000.
  - F → 0111000.

## Timing
- Reset values:
  - Outputs: `dig_en` = 0xFF and all `DN_*` = 1 on the edge after `fpga_rst` is sampled high.
  - Counters: `pcnt` = 0, `idx` = 0.
  - Registers: pending and shadow registers take their reset values.
- Write latency:
  - `bus_rdata` reflects a write from the next cycle.
  - Pins reflect it one cycle after the next frame boundary.
- Output latency: outputs lag `idx` by exactly 1 cycle, and each digit is held for exactly SCAN_DIV cycles.
- Back-to-back writes within one frame: only the last write reaches the shadow.
- Simultaneous write to DATA and a frame boundary: the write is captured by the shadow on that same edge.
- Reset mid-frame: all state returns to reset values on that edge, and scanning restarts at digit 0 once `fpga_rst` is deasserted.
- Writes while `fpga_rst` is high are ignored.

## Configuration
- Macro: `SEG7_LZB_EN`, which enables leading-zero blanking.
- Defined:
  - Digit i (i ≥ 1) is blanked when all shadow nibbles i..7 are zero.
  - A blanked digit drives `dig_en` bit = 1 and all segments = 1.
  - Digit 0 is never blanked.
  - Blanking applies after the MASK enable.
- Undefined: leading zeros display as "0".

## Structure
- Package `seg7_pkg`:
  - NUM_DIGITS = 8.
  - Offsets DATA_OFS = 4'h0 and MASK_OFS = 4'h4.
  - Reset constants DATA_RST and MASK_RST.
  - 7-bit glyph constants for 0–F.
- Sub-module `hex7seg_decode`: combinational; 4-bit nibble in, 7-bit active-low A..G out.

## Test plan
All scenarios use SCAN_DIV = 4.
- **Reset:** hold `fpga_rst` for 3 cycles → `dig_en` = 0xFF, all `DN_*` = 1, `bus_rdata` at 0x0 = 0 and at 0x4 = 0xFF.
- **Frame-boundary update:**
  - Stimulus: write DATA = 0x1234_5678 while `idx` = 3.
  - Next cycle: `bus_rdata` = 0x1234_5678.
  - Until the boundary: the pins still show '0' glyphs.
  - After the boundary: `dig_en` = 0xFE with A..G = 0000000 for 4 cycles; digit 7 then shows 1001111.
- **Mask and decimal point:** write MASK = 0x0000_10F0 → digits 0–3 dark (`dig_en` = 0xFF in those slots); digit 4 lit with `DN_DP` = 0; digits 5–7 lit with `DN_DP` = 1.
- **Boundary collision:** write DATA = 0xFFFF_FFFF on the exact boundary cycle → the following frame shows 'F' (0111000) on all digits.
- **Leading-zero blanking:** write DATA = 0x0000_00A0.
  - With `SEG7_LZB_EN`: only digits 0 ('0') and 1 ('A') are lit.
  - Without it: all 8 digits are lit.
- **Reset mid-scan:** assert `fpga_rst` for 1 cycle at `idx` = 5 → next edge gives `dig_en` = 0xFF, DATA readback = 0, and scanning resumes at digit 0.
